raiz_iterativa: RTL and testbench

//  Sequential unsigned integer square root, digit-by-digit restoring method (2 radicand bits/iteration).

---
 rtl/raiz_pkg.sv | 8 +
 rtl/raiz_paso.sv | 21 ++
 rtl/raiz_iterativa.sv | 69 ++++++
 tb/tb_raiz_iterativa.sv | 124 ++++++++++++
 4 files changed

// File: rtl/raiz_pkg.sv
// raiz_pkg: shared FSM state type and default sizing for the iterative square root
package raiz_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int N_DEF = 16;
  localparam int ITER = N_DEF / 2;
  localparam int AW = N_DEF / 2 + 3;
  localparam int CW = $clog2(N_DEF / 2);
endpackage

// File: rtl/raiz_paso.sv
// raiz_paso: one restoring square-root step, trial subtract of (tmp<<2)+1 and restore mux
module raiz_paso #(
  parameter int H = 8
) (
  input  logic [H+2:0] a,
  input  logic [H-1:0] tmp,
  input  logic [1:0]   bits,
  output logic [H+2:0] a_next,
  output logic [H-1:0] tmp_next,
  output logic         sign
);
  localparam int W = H + 3;
  logic [W-1:0] ash, trial;
  always_comb begin
    ash = W'({a, bits});
    trial = ash - {1'b0, tmp, 2'b01};
    sign = trial[W-1];
    a_next = sign ? ash : trial;
    tmp_next = H'({tmp, ~sign});
  end
endmodule

// File: rtl/raiz_iterativa.sv
// raiz_iterativa: sequential digit-by-digit unsigned square root with start/busy/done handshake
module raiz_iterativa
  import raiz_pkg::*;
#(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   radicando,
  output logic           busy,
  output logic           done,
  output logic [N/2-1:0] raiz,
  output logic [N/2:0]   residuo
);
  localparam int H = N / 2;
  localparam int W = H + 3;
  localparam int C = $clog2(H);
  state_t state, state_n;
  logic [N-1:0] r;
  logic [W-1:0] a, a_n;
  logic [H-1:0] tmp, tmp_n;
  logic [C-1:0] cnt;
  logic last, sign;
  raiz_paso #(.H(H)) u_paso (
    .a        (a),
    .tmp      (tmp),
    .bits     (r[N-1:N-2]),
    .a_next   (a_n),
    .tmp_next (tmp_n),
    .sign     (sign)
  );
  assign last = cnt == C'(H - 1);
  assign busy = state == CALC;
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (start ? CALC : IDLE) :
              state == CALC ? (last ? DONE : CALC) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      r <= '0;
      a <= '0;
      tmp <= '0;
      cnt <= '0;
      raiz <= '0;
      residuo <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        r <= radicando;
        a <= '0;
        tmp <= '0;
        cnt <= '0;
      end else if (state == CALC) begin
        r <= {r[N-3:0], 2'b00};
        a <= a_n;
        tmp <= tmp_n;
        cnt <= cnt + 1'b1;
        if (last) begin
          raiz <= {tmp[H-2:0], ~sign};
          residuo <= a_n[H:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_raiz_iterativa.sv
// tb_raiz_iterativa: randomized and directed checks of raiz_iterativa against an arithmetic isqrt model
module tb_raiz_iterativa;
  logic clk = 0, rst_n = 0, start = 0;
  logic [15:0] radicando = '0;
  logic busy, done;
  logic [7:0] raiz;
  logic [8:0] residuo;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  raiz_iterativa #(.N(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .radicando (radicando),
    .busy      (busy),
    .done      (done),
    .raiz      (raiz),
    .residuo   (residuo)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int isqrt(input int x);
    int q = 0;
    for (int b = 128; b > 0; b >>= 1)
      if ((q + b) * (q + b) <= x) q += b;
    return q;
  endfunction

  task automatic op(input logic [15:0] x, input bit bump);
    int xv = int'(x);
    int q = isqrt(xv);
    start = 1;
    radicando = x;
    @(posedge clk); #1;
    start = 0;
    radicando = 16'($urandom);
    for (int i = 0; i < 8; i++) begin
      check("busy", 32'(busy), 1);
      check("done_early", 32'(done), 0);
      if (bump && i == 2) begin
        start = 1;
        radicando = 16'd100;
      end
      if (bump && i == 3) start = 0;
      @(posedge clk); #1;
    end
    check("done", 32'(done), 1);
    check("busy_in_done", 32'(busy), 0);
    check("raiz", 32'(raiz), q);
    check("residuo", 32'(residuo), xv - q * q);
    @(posedge clk); #1;
    check("done_pulse", 32'(done), 0);
    check("raiz_hold", 32'(raiz), q);
  endtask

  initial begin
    int seen, k;
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_raiz", 32'(raiz), 0);
    check("rst_residuo", 32'(residuo), 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    op(16'd0, 0);
    op(16'd16, 0);
    op(16'd17, 0);
    op(16'd15, 0);
    op(16'd50000, 1);
    op(16'd100, 0);
    repeat (60) begin
      k = $urandom_range(1, 255);
      op(16'(k * k - 1), 0);
      op(16'(k * k), 0);
    end
    repeat (200) op(16'($urandom), 0);
    op(16'd65535, 0);
    start = 1;
    radicando = 16'd200;
    @(posedge clk); #1;
    start = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_raiz", 32'(raiz), 0);
    check("abort_residuo", 32'(residuo), 0);
    @(posedge clk); #1;
    rst_n = 1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("no_done_after_abort", seen, 0);
    check("idle_after_abort", 32'(busy), 0);
    start = 1;
    radicando = 16'd17;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    start = 0;
    check("held_start_pulses", seen, 4);
    repeat (12) @(posedge clk);
    #1;
    check("held_start_raiz", 32'(raiz), 4);
    check("held_start_residuo", 32'(residuo), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
